// File: rtl/crop_frame_buffer.sv
// Single-frame capture buffer between the crop/downsample stage and the SPART transmitter.
// Fills one raster frame into RAM, then streams it out once over a valid/ready handshake.
module crop_frame_buffer #(
    parameter int NUM_PIXELS = 784,
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 10
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              buf_rst,
    input  logic              iDVAL,
    input  logic [DATA_W-1:0] iDATA,
    input  logic              iSTART,
    input  logic              iREADY,
    output logic [DATA_W-1:0] oDATA,
    output logic              oDVAL,
    output logic              oFULL,
    output logic              oBUSY,
    output logic              oOVF,
    output logic [ADDR_W-1:0] oCOUNT
);

    typedef enum logic [1:0] {IDLE, FILL, FULL, DRAIN} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);
    localparam logic [ADDR_W-1:0] END_ADDR  = ADDR_W'(NUM_PIXELS);

    state_t            state;
    logic [ADDR_W-1:0] wrPtr;
    logic [ADDR_W-1:0] rdPtr;
    logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];
    logic [DATA_W-1:0] ramData_p1;
    logic              vld_p1;

    logic advance;
    logic rdEn;
    logic wrEn;
    logic lastXfer;

    // The output register can take a new byte when empty or when its byte leaves this cycle.
    assign advance  = !oDVAL || iREADY;
    assign wrEn     = (state == FILL) && !buf_rst && iDVAL;
    assign rdEn     = (state == DRAIN) && !buf_rst && (rdPtr != END_ADDR) && (!vld_p1 || advance);
    assign lastXfer = (state == DRAIN) && (rdPtr == END_ADDR) && !vld_p1 && oDVAL && iREADY;
    assign oCOUNT   = wrPtr;

    // Stage p1: synchronous RAM read; the read data holds whenever no read is issued,
    // so it doubles as the skid slot behind the output register.
    always_ff @(posedge iCLK) begin
        if (wrEn)
            mem[wrPtr] <= iDATA;
        if (rdEn)
            ramData_p1 <= mem[rdPtr];
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state  <= IDLE;
            wrPtr  <= '0;
            rdPtr  <= '0;
            vld_p1 <= 1'b0;
            oDATA  <= '0;
            oDVAL  <= 1'b0;
            oFULL  <= 1'b0;
            oBUSY  <= 1'b0;
            oOVF   <= 1'b0;
        end else if (buf_rst) begin
            state  <= FILL;
            wrPtr  <= '0;
            rdPtr  <= '0;
            vld_p1 <= 1'b0;
            oDVAL  <= 1'b0;
            oFULL  <= 1'b0;
            oBUSY  <= 1'b0;
            oOVF   <= 1'b0;
        end else begin
            if (iDVAL && (state == FULL || state == DRAIN))
                oOVF <= 1'b1;

            case (state)
                FILL: begin
                    if (iDVAL) begin
                        wrPtr <= wrPtr + 1'b1;
                        if (wrPtr == LAST_ADDR) begin
                            state <= FULL;
                            oFULL <= 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (iSTART) begin
                        state  <= DRAIN;
                        oFULL  <= 1'b0;
                        oBUSY  <= 1'b1;
                        rdPtr  <= '0;
                        vld_p1 <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (rdEn)
                        rdPtr <= rdPtr + 1'b1;

                    if (rdEn)
                        vld_p1 <= 1'b1;
                    else if (advance)
                        vld_p1 <= 1'b0;

                    // Stage p2: output register, held while the sink stalls.
                    if (vld_p1 && advance) begin
                        oDATA <= ramData_p1;
                        oDVAL <= 1'b1;
                    end else if (advance) begin
                        oDVAL <= 1'b0;
                    end

                    if (lastXfer) begin
                        state <= IDLE;
                        oBUSY <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_crop_frame_buffer.sv
// Bench for crop_frame_buffer: control-vector table plus randomized frames checked
// against a queue holding the captured frame.
module tb_crop_frame_buffer;

    localparam int NPIX = 784;

    logic       iCLK = 1'b0;
    logic       iRST;
    logic       buf_rst;
    logic       iDVAL;
    logic [7:0] iDATA;
    logic       iSTART;
    logic       iREADY;
    logic [7:0] oDATA;
    logic       oDVAL;
    logic       oFULL;
    logic       oBUSY;
    logic       oOVF;
    logic [9:0] oCOUNT;

    int checks   = 0;
    int failures = 0;

    logic [7:0] frameRef[$];

    crop_frame_buffer #(.NUM_PIXELS(NPIX), .DATA_W(8), .ADDR_W(10)) dut (
        .iCLK(iCLK), .iRST(iRST), .buf_rst(buf_rst), .iDVAL(iDVAL), .iDATA(iDATA),
        .iSTART(iSTART), .iREADY(iREADY), .oDATA(oDATA), .oDVAL(oDVAL),
        .oFULL(oFULL), .oBUSY(oBUSY), .oOVF(oOVF), .oCOUNT(oCOUNT)
    );

    always #5 iCLK = ~iCLK;

    typedef struct {
        logic       bufRst;
        logic       dval;
        logic [7:0] data;
        logic       start;
        int         expCount;
        logic       expFull;
        logic       expBusy;
        logic       expOvf;
        logic       expDval;
    } vec_t;

    vec_t tbl[9];

    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic doBufRst(input logic withSample);
        buf_rst = 1'b1;
        iDVAL   = withSample;
        iDATA   = 8'h5A;
        step();
        buf_rst = 1'b0;
        iDVAL   = 1'b0;
        frameRef.delete();
        chk("bufrst_count", int'(oCOUNT), 0);
        chk("bufrst_ovf", int'(oOVF), 0);
        chk("bufrst_full", int'(oFULL), 0);
        chk("bufrst_dval", int'(oDVAL), 0);
    endtask

    task automatic capture(input int n, input bit ramp, input int minGap, input int maxGap);
        for (int k = 0; k < n; k++) begin
            int idx;
            idx   = frameRef.size();
            iDVAL = 1'b1;
            iDATA = ramp ? 8'(idx) : 8'($urandom);
            frameRef.push_back(iDATA);
            step();
            iDVAL = 1'b0;
            chk("fill_count", int'(oCOUNT), frameRef.size());
            chk("fill_full", int'(oFULL), (frameRef.size() == NPIX) ? 1 : 0);
            repeat ($urandom_range(maxGap, minGap)) step();
        end
    endtask

    task automatic pulseStart();
        iSTART = 1'b1;
        step();
        iSTART = 1'b0;
    endtask

    // Full-rate drain: fixed first-byte latency and no bubbles; one iDVAL injected mid-stream.
    task automatic drainFull();
        iREADY = 1'b1;
        pulseStart();
        chk("drain_busy", int'(oBUSY), 1);
        chk("drain_full_clr", int'(oFULL), 0);
        chk("lat1_dval", int'(oDVAL), 0);
        step();
        chk("lat2_dval", int'(oDVAL), 0);
        step();
        for (int k = 0; k < NPIX; k++) begin
            chk("full_dval", int'(oDVAL), 1);
            chk("full_data", int'(oDATA), int'(frameRef[k]));
            iDVAL = (k == 300);
            iDATA = 8'hEE;
            step();
        end
        iDVAL = 1'b0;
        chk("full_end_dval", int'(oDVAL), 0);
        chk("full_end_busy", int'(oBUSY), 0);
        chk("full_end_ovf", int'(oOVF), 1);
        chk("full_end_count", int'(oCOUNT), NPIX);
        iREADY = 1'b0;
    endtask

    // Backpressured drain: pattern 1 gives iREADY = 1,0,0,1,0,0...; pattern 0 is random.
    task automatic drainStall(input int pat);
        int         idx;
        int         cyc;
        bit         held;
        logic [7:0] heldData;
        logic       rdy;
        idx  = 0;
        cyc  = 0;
        held = 1'b0;
        heldData = 8'h00;
        pulseStart();
        while (idx < NPIX && cyc < 20000) begin
            rdy    = (pat == 1) ? (cyc % 3 == 0) : ($urandom_range(2, 0) != 0);
            iREADY = rdy;
            if (held) begin
                chk("hold_dval", int'(oDVAL), 1);
                chk("hold_data", int'(oDATA), int'(heldData));
            end
            held = 1'b0;
            if (oDVAL) begin
                if (rdy) begin
                    chk("stall_data", int'(oDATA), int'(frameRef[idx]));
                    idx++;
                end else begin
                    held     = 1'b1;
                    heldData = oDATA;
                end
            end
            step();
            cyc++;
        end
        iREADY = 1'b0;
        chk("stall_bytes", idx, NPIX);
        chk("stall_end_dval", int'(oDVAL), 0);
        chk("stall_end_busy", int'(oBUSY), 0);
    endtask

    initial begin
        iRST = 1'b0; buf_rst = 1'b0; iDVAL = 1'b0; iDATA = 8'h00;
        iSTART = 1'b0; iREADY = 1'b0;
        repeat (3) step();
        chk("rst_dval", int'(oDVAL), 0);
        chk("rst_data", int'(oDATA), 0);
        chk("rst_full", int'(oFULL), 0);
        chk("rst_busy", int'(oBUSY), 0);
        chk("rst_ovf", int'(oOVF), 0);
        chk("rst_count", int'(oCOUNT), 0);
        iRST = 1'b1;
        step();

        // bufRst, dval, data, start, count, full, busy, ovf, dval
        tbl[0] = '{1'b0, 1'b1, 8'h05, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 8'hAA, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 8'h00, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 8'h11, 1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 8'h22, 1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 8'h33, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 8'h44, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{1'b0, 1'b0, 8'h00, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 9; i++) begin
            buf_rst = tbl[i].bufRst;
            iDVAL   = tbl[i].dval;
            iDATA   = tbl[i].data;
            iSTART  = tbl[i].start;
            step();
            buf_rst = 1'b0; iDVAL = 1'b0; iSTART = 1'b0;
            chk($sformatf("vec%0d_count", i), int'(oCOUNT), tbl[i].expCount);
            chk($sformatf("vec%0d_full", i), int'(oFULL), int'(tbl[i].expFull));
            chk($sformatf("vec%0d_busy", i), int'(oBUSY), int'(tbl[i].expBusy));
            chk($sformatf("vec%0d_ovf", i), int'(oOVF), int'(tbl[i].expOvf));
            chk($sformatf("vec%0d_dval", i), int'(oDVAL), int'(tbl[i].expDval));
        end

        // Frame A: ramp data at 21-cycle spacing, overflow in FULL, full-rate drain.
        doBufRst(1'b0);
        capture(NPIX, 1'b1, 20, 20);
        chk("A_ovf", int'(oOVF), 0);
        iDVAL = 1'b1; iDATA = 8'hFF;
        step();
        iDVAL = 1'b0;
        chk("A_full_ovf", int'(oOVF), 1);
        chk("A_full_hold", int'(oFULL), 1);
        chk("A_full_count", int'(oCOUNT), NPIX);
        drainFull();
        doBufRst(1'b0);

        // Frame B: iSTART at count 100 ignored, 1-0-0 backpressure drain.
        capture(100, 1'b0, 0, 2);
        pulseStart();
        chk("B_start_busy", int'(oBUSY), 0);
        step();
        chk("B_start_dval", int'(oDVAL), 0);
        chk("B_start_count", int'(oCOUNT), 100);
        capture(NPIX - 100, 1'b0, 0, 2);
        drainStall(1);

        // Frame C: buf_rst coinciding with a sample after 300 captures.
        doBufRst(1'b0);
        capture(300, 1'b0, 0, 1);
        doBufRst(1'b1);
        capture(NPIX, 1'b0, 0, 1);
        drainStall(0);

        // Reset in the middle of a drain.
        doBufRst(1'b0);
        capture(NPIX, 1'b0, 0, 0);
        iREADY = 1'b1;
        pulseStart();
        repeat (10) step();
        chk("mid_dval_pre", int'(oDVAL), 1);
        #3 iRST = 1'b0;
        #1;
        chk("mid_rst_dval", int'(oDVAL), 0);
        chk("mid_rst_data", int'(oDATA), 0);
        chk("mid_rst_busy", int'(oBUSY), 0);
        chk("mid_rst_count", int'(oCOUNT), 0);
        step();
        iRST = 1'b1;
        for (int i = 0; i < 4; i++) begin
            iSTART = (i % 2 == 0);
            iDVAL  = (i % 2 == 1);
            step();
        end
        iSTART = 1'b0; iDVAL = 1'b0;
        step();
        chk("post_busy", int'(oBUSY), 0);
        chk("post_full", int'(oFULL), 0);
        chk("post_dval", int'(oDVAL), 0);
        chk("post_count", int'(oCOUNT), 0);
        chk("post_ovf", int'(oOVF), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/crop_frame_buffer.md
Name: crop_frame_buffer

Overview:
- Sits directly downstream of the crop/downsample stage.
- Captures one 28x28 frame of 8-bit grayscale samples, delivered as iDVAL-qualified pulses in raster order, into on-chip RAM.
- Once the frame is complete, streams the 784 bytes in capture order to the SPART transmit path over a valid/ready handshake.
- Capture is armed by buf_rst and the stream is started by iSTART, so each frame is captured and sent exactly once.

Parameters:
NUM_PIXELS, 784, samples per frame (28x28)
DATA_W, 8, sample width in bits
ADDR_W, 10, RAM address width; 2^ADDR_W >= NUM_PIXELS

Ports:
iCLK  in  1  clock; all logic on rising edge
iRST  in  1  asynchronous active-low reset
buf_rst  in  1  synchronous clear/arm; returns block to FILL with pointers zeroed
iDVAL  in  1  input sample valid (single-cycle pulses from the crop stage)
iDATA  in  DATA_W  input sample
iSTART  in  1  single-cycle request to begin draining a FULL buffer
iREADY  in  1  downstream accepts oDATA this cycle when oDVAL=1
oDATA  out  DATA_W  output byte
oDVAL  out  1  output byte valid
oFULL  out  1  high in FULL state
oBUSY  out  1  high in DRAIN state
oOVF  out  1  sticky: iDVAL seen in FULL or DRAIN
oCOUNT  out  ADDR_W  samples written this frame (wr_ptr)

Behaviour:
- States:
  - IDLE: no capture.
  - FILL: capturing.
  - FULL: frame held.
  - DRAIN: streaming.
- Reset (iRST=0, asynchronous):
  - State goes to IDLE; wr_ptr=0, rd_ptr=0.
  - oDVAL=0, oDATA=0, oFULL=0, oBUSY=0, oOVF=0, oCOUNT=0.
  - RAM contents are don't-care.
- buf_rst=1, in any state: next state FILL; wr_ptr=0, rd_ptr=0, oDVAL=0, oOVF=0.
  - buf_rst overrides iDVAL, iSTART and iREADY in the same cycle; a sample arriving then is dropped.
- IDLE:
  - iDVAL is ignored and does not set oOVF.
  - iSTART is ignored.
- FILL:
  - Each cycle with iDVAL=1 writes iDATA to RAM[wr_ptr] and increments wr_ptr.
  - The write at wr_ptr=NUM_PIXELS-1 moves the state to FULL on the next cycle; wr_ptr/oCOUNT then reads NUM_PIXELS.
  - iSTART is ignored in FILL.
- FULL:
  - oFULL=1; holds until iSTART or buf_rst.
  - iDVAL sets oOVF and is not written.
  - iSTART moves the state to DRAIN.
- DRAIN:
  - oBUSY=1. RAM read is synchronous (1-cycle).
  - First oDVAL rises exactly 2 cycles after the iSTART cycle, carrying RAM[0].
  - A byte transfers on any cycle with oDVAL=1 and iREADY=1.
  - While oDVAL=1 and iREADY=0, oDATA and oDVAL hold stable (no change, no skip).
  - With iREADY held high, bytes transfer on consecutive cycles (one per cycle, no bubbles) after the first. Implement with prefetch/skid register as needed.
  - iDVAL sets oOVF.
  - The transfer of byte NUM_PIXELS-1 ends the drain: next cycle oDVAL=0, oBUSY=0, state IDLE.
- oDATA keeps its last value when oDVAL=0.
- Ordering: output byte k equals the k-th captured sample, k=0..NUM_PIXELS-1.
- Pointer widths: ADDR_W, no wrap; pointers never exceed NUM_PIXELS.
- Reset mid-DRAIN: outputs drop within the reset assertion. After release, the block stays in IDLE until buf_rst.

Test Plan:
- Reset, buf_rst pulse, 784 iDVAL pulses with iDATA=k[7:0] spaced 21 cycles apart -> oFULL=1 one cycle after the 784th write, oCOUNT=784, oOVF=0.
- From FULL, iSTART with iREADY=1 held -> oDVAL first high 2 cycles after iSTART, then 784 consecutive cycles carrying 0,1,...,255,0,..., then oDVAL=0 and oBUSY=0.
- During drain, iREADY toggled with pattern 1,0,0,1,... -> every byte appears exactly once in order; oDATA is stable across all iREADY=0 cycles.
- iDVAL pulses in FULL and in DRAIN -> oOVF=1 and stays 1; output stream unchanged. A following buf_rst clears oOVF to 0.
- buf_rst asserted after 300 captures, coinciding with an iDVAL -> oCOUNT=0 next cycle, that sample not stored; the next 784 samples fill a clean frame.
- iSTART during FILL (oCOUNT=100) and in IDLE after reset -> no state change, oDVAL stays 0. iRST asserted mid-DRAIN -> all outputs 0 immediately; block stays in IDLE after release.
